// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared mode encodings and FSM state type for the registered decoder
package decoder_pkg;

  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERMO = 2'b01;
  localparam logic [1:0] MODE_INV    = 2'b10;
  localparam logic [1:0] MODE_SCAN   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_n_comb.sv
// rtl/decoder_n_comb.sv - combinational code-to-word generator (one-hot, thermometer, inverted one-hot)
module decoder_n_comb
  import decoder_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic [1:0]             mode,
  input  logic [IN_W-1:0]        code,
  output logic [(1<<IN_W)-1:0]   word
);

  localparam int OUT_W = 1 << IN_W;

  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] thermo;

  always_comb begin
    onehot = '0;
    thermo = '0;
    for (int i = 0; i < OUT_W; i++) begin
      onehot[i] = (code == IN_W'(i));
      thermo[i] = (IN_W'(i) <= code);
    end
  end

  // Scan steps are fed in as one-hot, so MODE_SCAN shares that encoding here.
  always_comb begin
    word = onehot;
    case (mode)
      MODE_THERMO: word = thermo;
      MODE_INV:    word = ~onehot;
      default:     word = onehot;
    endcase
  end

endmodule

// File: rtl/decoder_n_seq.sv
// rtl/decoder_n_seq.sv - registered IN_W-to-2**IN_W decoder with valid/ready handshake and scan mode
module decoder_n_seq
  import decoder_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_code,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<IN_W)-1:0]  out,
  output logic                  scan_busy
);

  localparam int OUT_W = 1 << IN_W;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    idx_q, idx_d;
  logic [IN_W-1:0]    target_q, target_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;

  logic               in_fire;
  logic               out_fire;
  logic [1:0]         gen_mode;
  logic [IN_W-1:0]    gen_code;
  logic [OUT_W-1:0]   gen_word;

  assign in_ready  = en & (state_q == IDLE) & (~out_valid_q | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign scan_busy = (state_q == SCAN);

  // A new input owns the generator; otherwise it precomputes the next scan step.
  always_comb begin
    gen_mode = MODE_ONEHOT;
    gen_code = idx_q + IN_W'(1);
    if (in_fire) begin
      gen_mode = (mode == MODE_SCAN) ? MODE_ONEHOT : mode;
      gen_code = (mode == MODE_SCAN) ? '0 : in_code;
    end
  end

  decoder_n_comb #(
    .IN_W (IN_W)
  ) u_comb (
    .mode (gen_mode),
    .code (gen_code),
    .word (gen_word)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    target_d    = target_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (in_fire) begin
      out_d       = gen_word;
      out_valid_d = 1'b1;
      if (mode == MODE_SCAN) begin
        state_d  = SCAN;
        idx_d    = '0;
        target_d = in_code;
      end
    end else if (out_fire) begin
      if (state_q == SCAN && idx_q != target_q) begin
        idx_d = idx_q + IN_W'(1);
        out_d = gen_word;
      end else begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      target_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      target_q    <= target_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_decoder_n_seq.sv
// tb/tb_decoder_n_seq.sv - scoreboard bench for decoder_n_seq (IN_W=2 and IN_W=3 instances)
module tb_decoder_n_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       en = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_code = '0;
  logic [1:0] mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out;
  logic       scan_busy;

  logic       en3 = 1'b1;
  logic       in_valid3 = 1'b0;
  logic       in_ready3;
  logic [2:0] in_code3 = '0;
  logic [1:0] mode3 = '0;
  logic       out_valid3;
  logic       out_ready3 = 1'b1;
  logic [7:0] out3;
  logic       scan_busy3;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [7:0] exp3_q[$];

  always #5 clk = ~clk;

  decoder_n_seq #(.IN_W(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .scan_busy(scan_busy)
  );

  decoder_n_seq #(.IN_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_code(in_code3), .mode(mode3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out(out3), .scan_busy(scan_busy3)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every word handed downstream is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word2: got %b expected none (queue empty) at %0t", out, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (out !== e) begin
          errors++;
          $display("FAIL word2: got %b expected %b at %0t", out, e, $time);
        end
      end
    end
    if (!rst && out_valid3 && out_ready3) begin
      checks++;
      if (exp3_q.size() == 0) begin
        errors++;
        $display("FAIL word3: got %b expected none (queue empty) at %0t", out3, $time);
      end else begin
        logic [7:0] e3;
        e3 = exp3_q.pop_front();
        if (out3 !== e3) begin
          errors++;
          $display("FAIL word3: got %b expected %b at %0t", out3, e3, $time);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [1:0] m, input logic [1:0] c);
    int n;
    in_valid = 1'b1;
    mode     = m;
    in_code  = c;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_out", {4'b0, out}, 8'h00);
    check("rst_valid", {7'b0, out_valid}, 8'h00);
    check("rst_busy", {7'b0, scan_busy}, 8'h00);
    check("rst_out3", out3, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back one-hot at full throughput
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 2'(i));
      in_valid = (i < 3);
      check("t1_valid", {7'b0, out_valid}, 8'h01);
      check("t1_ready", {7'b0, in_ready}, 8'h01);
    end

    // Thermometer and inverted modes including boundaries
    exp_q.push_back(4'b0111); issue(2'b01, 2'd2);
    exp_q.push_back(4'b1101); issue(2'b10, 2'd1);
    exp_q.push_back(4'b0001); issue(2'b01, 2'd0);
    exp_q.push_back(4'b1111); issue(2'b01, 2'd3);
    @(posedge clk); #1;
    check("t2_drained", {7'b0, out_valid}, 8'h00);

    // Scan to code 2
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    issue(2'b11, 2'd2);
    for (int i = 0; i < 3; i++) begin
      check("t3_busy", {7'b0, scan_busy}, 8'h01);
      check("t3_inrdy", {7'b0, in_ready}, 8'h00);
      @(posedge clk); #1;
    end
    check("t3_valid_end", {7'b0, out_valid}, 8'h00);
    check("t3_busy_end", {7'b0, scan_busy}, 8'h00);
    check("t3_inrdy_end", {7'b0, in_ready}, 8'h01);

    // Backpressure holds the word and blocks a pending request
    out_ready = 1'b0;
    exp_q.push_back(4'b1000);
    issue(2'b00, 2'd3);
    in_valid = 1'b1; mode = 2'b00; in_code = 2'd1;
    for (int i = 0; i < 4; i++) begin
      check("t4_out", {4'b0, out}, 8'h08);
      check("t4_valid", {7'b0, out_valid}, 8'h01);
      check("t4_inrdy", {7'b0, in_ready}, 8'h00);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    exp_q.push_back(4'b0010);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t4_replace", {4'b0, out}, 8'h02);
    check("t4_replace_v", {7'b0, out_valid}, 8'h01);
    @(posedge clk); #1;

    // Reset mid-scan aborts the sequence
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    issue(2'b11, 2'd3);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_out", {4'b0, out}, 8'h00);
    check("t5_valid", {7'b0, out_valid}, 8'h00);
    check("t5_busy", {7'b0, scan_busy}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(4'b0010);
    issue(2'b00, 2'd1);
    check("t5_after", {4'b0, out}, 8'h02);
    @(posedge clk); #1;

    // en=0 blocks acceptance
    en = 1'b0;
    in_valid = 1'b1; mode = 2'b00; in_code = 2'd2;
    #1;
    check("t6_inrdy", {7'b0, in_ready}, 8'h00);
    @(posedge clk); #1;
    check("t6_notx", {7'b0, out_valid}, 8'h00);
    in_valid = 1'b0;
    en = 1'b1;

    // IN_W=3 one-hot code 5
    exp3_q.push_back(8'b0010_0000);
    in_valid3 = 1'b1; mode3 = 2'b00; in_code3 = 3'd5;
    #1;
    check("t6_inrdy3", {7'b0, in_ready3}, 8'h01);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    check("t6_out3", out3, 8'b0010_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;

    check("q2_empty", 8'(exp_q.size()), 8'h00);
    check("q3_empty", 8'(exp3_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
